spm_serdes_ctrl: RTL and testbench

//   Sequencer that sits directly around the spm serial-parallel multiplier.

---
 rtl/spm_serdes_ctrl_if.sv | 25 ++
 rtl/spm_serdes_ctrl.sv | 111 +++++++++++
 tb/tb_spm_serdes_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/spm_serdes_ctrl_if.sv
// Operand/product handshake bundle between a producer/consumer and the
// spm serializer controller.
interface spm_serdes_ctrl_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_x;
   logic [WIDTH-1:0]     in_a;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out_p;

   // Controller side: accepts operands, produces the product.
   modport slave (
      input  in_valid, in_x, in_a, out_ready,
      output in_ready, out_valid, out_p
   );

   // Producer/consumer side.
   modport master (
      output in_valid, in_x, in_a, out_ready,
      input  in_ready, out_valid, out_p
   );
endinterface

// File: rtl/spm_serdes_ctrl.sv
// Sequencer around the spm serial-parallel multiplier: latches operands,
// clears spm, streams x LSB first, and collects the serial product.
module spm_serdes_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   spm_serdes_ctrl_if.slave   bus,
   output logic               busy,
   output logic               spm_rst,
   output logic               spm_x,
   output logic [WIDTH-1:0]   spm_a,
   input  logic               spm_y
);

   localparam int unsigned CNT_W = $clog2(2*WIDTH+1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2*WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLR,
      S_RUN,
      S_DONE
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [CNT_W-1:0]     r_cnt;
   logic [WIDTH-1:0]     r_xsr;
   logic [WIDTH-1:0]     r_a_q;
   logic [2*WIDTH-1:0]   r_p_q;
   logic [2*WIDTH-1:0]   r_out_p;
   logic [2*WIDTH-1:0]   w_p_shift;
   logic                 w_last;

   assign w_p_shift = {spm_y, r_p_q[2*WIDTH-1:1]};
   assign w_last    = (r_cnt == LAST_CNT);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode; in_valid outside IDLE is simply never looked at.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.in_valid)  w_next = S_CLR;
         S_CLR:                      w_next = S_RUN;
         S_RUN:   if (w_last)        w_next = S_DONE;
         S_DONE:  if (bus.out_ready) w_next = S_IDLE;
         default:                    w_next = S_IDLE;
      endcase
   end

   // Operand capture, x shifting, product collection and bit counter.
   // The finished product is copied into a separate output register on the
   // last RUN edge so out_p keeps the previous result while p_q is rebuilt.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt   <= '0;
         r_xsr   <= '0;
         r_a_q   <= '0;
         r_p_q   <= '0;
         r_out_p <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_xsr <= bus.in_x;
                  r_a_q <= bus.in_a;
                  r_p_q <= '0;
               end
            end
            S_CLR: begin
               r_cnt <= '0;
            end
            S_RUN: begin
               r_xsr <= {1'b0, r_xsr[WIDTH-1:1]};
               // cnt=0 sample is spm's pipeline fill and is dropped.
               if (r_cnt != '0) begin
                  r_p_q <= w_p_shift;
               end
               // Counter stops at the last value so the compare never wraps.
               if (w_last) begin
                  r_out_p <= w_p_shift;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Output decode from registered state only.
   always_comb begin
      bus.in_ready  = (r_state == S_IDLE);
      bus.out_valid = (r_state == S_DONE);
      bus.out_p     = r_out_p;
      busy          = (r_state != S_IDLE);
      spm_rst       = (r_state == S_RUN);
      spm_x         = (r_state == S_RUN) ? r_xsr[0] : 1'b0;
      spm_a         = r_a_q;
   end

endmodule

// File: tb/tb_spm_serdes_ctrl.sv
// Self-checking bench for spm_serdes_ctrl with a behavioural spm stand-in.
module tb_spm_serdes_ctrl;

   localparam int unsigned W = 32;
   localparam int LAT = 2*W + 2;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           busy;
   logic           spm_rst;
   logic           spm_x;
   logic [W-1:0]   spm_a;
   logic           spm_y;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   spm_serdes_ctrl_if #(.WIDTH(W)) bus ();

   spm_serdes_ctrl #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .busy    (busy),
      .spm_rst (spm_rst),
      .spm_x   (spm_x),
      .spm_a   (spm_a),
      .spm_y   (spm_y)
   );

   // Stand-in for spm: bit-serial accumulate, one product bit per clock,
   // registered output (one cycle latency), cleared while spm_rst is low.
   logic [W:0] spm_acc;
   always @(posedge clk) begin : spm_model
      logic [W:0] t;
      if (!spm_rst) begin
         spm_acc <= '0;
         spm_y   <= 1'b0;
      end else begin
         t = spm_acc + (spm_x ? {1'b0, spm_a} : '0);
         spm_y   <= t[0];
         spm_acc <= t >> 1;
      end
   end

   typedef struct {
      logic [W-1:0]   x;
      logic [W-1:0]   a;
      logic [2*W-1:0] p;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      if (bus.in_ready !== 1'b1) check({name, "_ready_timeout"}, 64'(bus.in_ready), 64'd1);
   endtask

   // Issue one operation and wait for out_valid. inject_at>0 pulses a
   // bogus in_valid that many cycles after the accept edge.
   task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] a,
                         input int inject_at, output logic [2*W-1:0] p, output int lat);
      lat = 0;
      p   = '0;
      wait_ready(name);
      bus.in_valid = 1'b1;
      bus.in_x     = x;
      bus.in_a     = a;
      tick();
      bus.in_valid = 1'b0;
      bus.in_x     = '0;
      bus.in_a     = '0;
      for (int i = 1; i <= 200; i++) begin
         tick();
         if (i == inject_at) begin
            bus.in_valid = 1'b1;
            bus.in_x     = 32'h12345678;
            bus.in_a     = 32'h0000FFFF;
         end else if (i == inject_at + 1) begin
            bus.in_valid = 1'b0;
            bus.in_x     = '0;
            bus.in_a     = '0;
         end
         if (bus.out_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
      p = bus.out_p;
      check({name, "_latency"}, 64'(lat), 64'(LAT));
      check({name, "_in_ready_done"}, 64'(bus.in_ready), 64'd0);
   endtask

   initial begin
      logic [2*W-1:0] p;
      logic [2*W-1:0] exp;
      logic [W-1:0]   x;
      logic [W-1:0]   a;
      int             lat;

      vecs[0] = '{x: 32'h00000003, a: 32'h00000005, p: 64'h000000000000000F};
      vecs[1] = '{x: 32'hFFFFFFFF, a: 32'hFFFFFFFF, p: 64'hFFFFFFFE00000001};
      vecs[2] = '{x: 32'h00000000, a: 32'hFFFFFFFF, p: 64'h0000000000000000};
      vecs[3] = '{x: 32'hFFFFFFFF, a: 32'h00000000, p: 64'h0000000000000000};
      vecs[4] = '{x: 32'h00000001, a: 32'h80000000, p: 64'h0000000080000000};
      vecs[5] = '{x: 32'h80000000, a: 32'h80000000, p: 64'h4000000000000000};
      vecs[6] = '{x: 32'hFFFFFFFF, a: 32'h00000001, p: 64'h00000000FFFFFFFF};

      bus.in_valid  = 1'b0;
      bus.in_x      = '0;
      bus.in_a      = '0;
      bus.out_ready = 1'b1;

      // Reset state.
      rst = 1'b0;
      repeat (3) tick();
      check("rst_in_ready",  64'(bus.in_ready),  64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_p",     64'(bus.out_p),     64'd0);
      check("rst_busy",      64'(busy),          64'd0);
      check("rst_spm_rst",   64'(spm_rst),       64'd0);
      check("rst_spm_x",     64'(spm_x),         64'd0);
      check("rst_spm_a",     64'(spm_a),         64'd0);
      rst = 1'b1;
      tick();

      // Directed vector table.
      for (int i = 0; i < 7; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].a, 0, p, lat);
         check($sformatf("vec%0d_p", i), p, vecs[i].p);
      end

      // Backpressure held in DONE for 10 cycles.
      tick();
      bus.out_ready = 1'b0;
      x   = 32'hDEADBEEF;
      a   = 32'h01234567;
      exp = {32'b0, x} * {32'b0, a};
      run_op("bp", x, a, 0, p, lat);
      check("bp_p", p, exp);
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("bp_hold_valid%0d", i), 64'(bus.out_valid), 64'd1);
         check($sformatf("bp_hold_p%0d", i),     bus.out_p,          exp);
         check($sformatf("bp_hold_rdy%0d", i),   64'(bus.in_ready),  64'd0);
      end
      bus.out_ready = 1'b1;
      tick();
      check("bp_release_ready", 64'(bus.in_ready),  64'd1);
      check("bp_release_valid", 64'(bus.out_valid), 64'd0);
      check("bp_release_p_hold", bus.out_p,         exp);

      // in_valid pulsed during RUN must be ignored.
      x   = 32'hA5A5A5A5;
      a   = 32'h0F0F0F0F;
      exp = {32'b0, x} * {32'b0, a};
      run_op("ignore", x, a, 12, p, lat);
      check("ignore_p", p, exp);

      // Reset in the middle of RUN (cnt=20).
      wait_ready("midrst");
      bus.in_valid = 1'b1;
      bus.in_x     = 32'hCAFEF00D;
      bus.in_a     = 32'h13572468;
      tick();
      bus.in_valid = 1'b0;
      repeat (21) tick();
      check("midrst_running", 64'(spm_rst), 64'd1);
      rst = 1'b0;
      tick();
      check("midrst_in_ready",  64'(bus.in_ready),  64'd1);
      check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      check("midrst_spm_rst",   64'(spm_rst),       64'd0);
      check("midrst_busy",      64'(busy),          64'd0);
      rst = 1'b1;
      run_op("post_rst", 32'h00000007, 32'h00000009, 0, p, lat);
      check("post_rst_p", p, 64'h000000000000003F);

      // Back-to-back random operations against plain multiplication.
      for (int i = 0; i < 20; i++) begin
         x = $urandom;
         a = $urandom;
         if (i == 3) x = '1;
         if (i == 7) a = '1;
         exp = {32'b0, x} * {32'b0, a};
         run_op($sformatf("rnd%0d", i), x, a, 0, p, lat);
         check($sformatf("rnd%0d_p", i), p, exp);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
